// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader: read-side sequencer for the packet buffer RAM driver.
// Streams len bytes starting at start_addr from a circular buffer. Reads are
// credit-limited into a small FIFO so the variable RAM read latency is hidden.
// Optional abort support is compiled in with `define PACKET_BUFFER_READER_ABORT_EN.
module packet_buffer_reader #(
  parameter int unsigned RAM_SIZE     = 4096,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned AW = $clog2(RAM_SIZE),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          ram_read_req,
  output logic [AW-1:0] ram_read_addr,
  input  logic          ram_read_ready,
  input  logic [7:0]    ram_read_out,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready
`ifdef PACKET_BUFFER_READER_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("READ_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StFlush} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, next_addr;
  logic          req_q, req_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [LW-1:0] emit_left_q, emit_left_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          zero_done_q, zero_done_d;
  logic          pop, wr_en, can_issue, abort_hit, flushing;
  int unsigned   committed;

`ifdef PACKET_BUFFER_READER_ABORT_EN
  assign abort_hit = abort & ((state_q == StIssue) | (state_q == StDrain));
  assign flushing  = (state_q == StFlush);
`else
  assign abort_hit = 1'b0;
  assign flushing  = 1'b0;
`endif

  assign pop       = out_valid & out_ready;
  // Reads landing while flushing belong to an aborted transfer and are dropped.
  assign wr_en     = ram_read_ready & ~flushing;
  assign next_addr = (addr_q == AW'(RAM_SIZE - 1)) ? '0 : addr_q + AW'(1);

  // Slots spoken for after this edge: in flight, just requested and queued.
  // The byte leaving this cycle frees its slot before any new read can land.
  always_comb begin
    committed = 32'(outstanding_q) + 32'(req_q) + 32'(count_q) - 32'(pop);
    can_issue = committed < FIFO_DEPTH;
  end

  // Outstanding reads: up on a presented request, down on returned data.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_q && !ram_read_ready) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_q && ram_read_ready) begin
      outstanding_d = outstanding_q - CW'(1);
    end
  end

  // Sequencer next state, request/address generation and byte accounting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = 1'b0;
    remaining_d = remaining_q;
    emit_left_d = emit_left_q;
    zero_done_d = 1'b0;
    if (pop) begin
      emit_left_d = emit_left_q - LW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            // First read goes out with the start edge so it appears next cycle.
            req_d       = 1'b1;
            addr_d      = start_addr;
            remaining_d = len - LW'(1);
            emit_left_d = len;
            state_d     = (len == LW'(1)) ? StDrain : StIssue;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (can_issue) begin
          req_d       = 1'b1;
          addr_d      = next_addr;
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
`ifdef PACKET_BUFFER_READER_ABORT_EN
      StFlush: begin
        if (outstanding_d == '0) begin
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef PACKET_BUFFER_READER_ABORT_EN
    if (abort_hit) begin
      req_d   = 1'b0;
      addr_d  = addr_q;
      state_d = (outstanding_d == '0) ? StDone : StFlush;
    end
`endif
  end

  // FIFO pointer and occupancy update; an abort empties it outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (abort_hit) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      req_q         <= 1'b0;
      remaining_q   <= '0;
      emit_left_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      remaining_q   <= remaining_d;
      emit_left_q   <= emit_left_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      zero_done_q   <= zero_done_d;
    end
  end

  // FIFO storage; cleared on reset so out_data reads 0 when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && !abort_hit) begin
      mem_q[wr_ptr_q] <= ram_read_out;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone) | zero_done_q;
  assign ram_read_req  = req_q;
  assign ram_read_addr = addr_q;
  assign out_valid     = (count_q != '0);
  assign out_data      = mem_q[rd_ptr_q];
  assign out_last      = out_valid & (emit_left_q == LW'(1));

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Testbench for packet_buffer_reader: RAM model with fixed latency holding
// byte[i] = i mod 256, expected-byte scoreboard and an independent monitor.
`timescale 1ns/1ps
module tb_packet_buffer_reader;
  localparam int unsigned RAM_SIZE     = 4096;
  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned AW           = 12;
  localparam int unsigned LW           = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, ram_read_req, ram_read_ready;
  logic [AW-1:0] ram_read_addr;
  logic [7:0]    ram_read_out, out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
`ifdef PACKET_BUFFER_READER_ABORT_EN
  logic          abort = 1'b0;
`endif

  packet_buffer_reader #(
    .RAM_SIZE(RAM_SIZE), .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
    .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
`ifdef PACKET_BUFFER_READER_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // RAM driver model: data returns READ_LATENCY cycles after the request.
  logic [READ_LATENCY-1:0] pv;
  logic [AW-1:0]           pa [READ_LATENCY];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pa[i] <= '0;
    end else begin
      pv[0] <= ram_read_req;
      pa[0] <= ram_read_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  assign ram_read_ready = pv[READ_LATENCY-1];
  assign ram_read_out   = pa[READ_LATENCY-1][7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t          sb[$];
  exp_t          e;
  logic [AW-1:0] req_log[$];
  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, hs_cnt = 0, last_cnt = 0, valid_cycles = 0;
  int start_cyc = 0, first_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit first_seen = 1'b0, stall_prev = 1'b0;
  logic [7:0] stall_d;
  logic       stall_l;

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (start && !busy) begin
        start_cyc  = cyc;
        first_seen = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram_read_req) req_log.push_back(ram_read_addr);
      if (busy) begin
        n_cmp++;
        if (32'(dut.outstanding_q) + 32'(dut.count_q) > FIFO_DEPTH) begin
          n_err++;
          $display("FAIL credit: outstanding+count=%0d limit %0d",
                   32'(dut.outstanding_q) + 32'(dut.count_q), FIFO_DEPTH);
        end
      end
      if (ram_read_ready) begin
        n_cmp++;
        if (32'(dut.count_q) >= FIFO_DEPTH) begin
          n_err++;
          $display("FAIL fifo_overflow: write with count=%0d", dut.count_q);
        end
      end
      if (stall_prev) begin
        n_cmp++;
        if (!out_valid || out_data !== stall_d || out_last !== stall_l) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                   out_valid, out_data, out_last, stall_d, stall_l);
        end
      end
      if (out_valid) begin
        valid_cycles++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
        end
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (out_last) begin
          last_cnt++;
          last_hs_cyc = cyc;
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got d=%0d l=%0b expected none", out_data, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            n_err++;
            $display("FAIL stream_byte: got d=%0d l=%0b expected d=%0d l=%0b",
                     out_data, out_last, e.d, e.l);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_d    = out_data;
      stall_l    = out_last;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req"}, ram_read_req, 0);
    check({tag, "_addr"}, ram_read_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
  endtask

  task automatic push_exp(input int addr, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t x;
      int   a;
      a   = (addr + i) % RAM_SIZE;
      x.d = a[7:0];
      x.l = (i == n - 1);
      sb.push_back(x);
    end
  endtask

  task automatic do_start(input int addr, input int n, input bit expect_it);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(addr);
    len        = LW'(n);
    if (expect_it) push_exp(addr, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for the next done pulse; bp selects the 1,0,0,1 out_ready pattern.
  task automatic run_wait(input string name, input int budget, input bit bp);
    logic [3:0] pat;
    int  base;
    bit  ok;
    pat  = 4'b1001;
    base = done_cnt;
    ok   = 1'b0;
    for (int k = 0; k < budget; k++) begin
      out_ready = bp ? pat[k % 4] : 1'b1;
      @(posedge clk); #1;
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  int base_hs, base_done, base_valid, base_last;
  int exp_a[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs_zero("rst");

    // Basic read
    base_hs = hs_cnt;
    do_start(10, 5, 1'b1);
    run_wait("basic", 50, 1'b0);
    check("basic_first_lat", first_cyc - start_cyc, 4);
    check("basic_contig", last_hs_cyc - first_cyc, 4);
    check("basic_done_lat", done_cyc - last_hs_cyc, 1);
    check("basic_count", hs_cnt - base_hs, 5);
    check("basic_sb_empty", sb.size(), 0);
    check("basic_busy_after", busy, 0);

    // Wrap-around
    req_log.delete();
    do_start(4094, 4, 1'b1);
    run_wait("wrap", 50, 1'b0);
    exp_a = '{4094, 4095, 0, 1};
    check("wrap_req_count", req_log.size(), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) check("wrap_req_addr", req_log[i], exp_a[i]);
    check("wrap_sb_empty", sb.size(), 0);

    // Backpressure
    base_hs   = hs_cnt;
    base_last = last_cnt;
    do_start(100, 8, 1'b1);
    run_wait("bp", 200, 1'b1);
    check("bp_count", hs_cnt - base_hs, 8);
    check("bp_last_count", last_cnt - base_last, 1);
    check("bp_sb_empty", sb.size(), 0);

    // Zero length
    base_valid = valid_cycles;
    base_done  = done_cnt;
    do_start(20, 0, 1'b0);
    run_wait("zero", 10, 1'b0);
    check("zero_done_lat", done_cyc - start_cyc, 1);
    check("zero_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_no_valid", valid_cycles - base_valid, 0);
    check("zero_done_once", done_cnt - base_done, 1);

    // Start while busy is ignored
    base_hs   = hs_cnt;
    base_done = done_cnt;
    do_start(300, 6, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; start_addr = AW'(700); len = LW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    run_wait("busy_start", 100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_count", hs_cnt - base_hs, 6);
    check("busy_start_done_once", done_cnt - base_done, 1);
    check("busy_start_sb_empty", sb.size(), 0);

    // Reset mid-transfer
    do_start(50, 20, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base_hs = hs_cnt;
    do_start(200, 3, 1'b1);
    run_wait("post_rst", 50, 1'b0);
    check("post_rst_count", hs_cnt - base_hs, 3);
    check("post_rst_sb_empty", sb.size(), 0);

`ifdef PACKET_BUFFER_READER_ABORT_EN
    // Abort on the third output byte
    begin
      int k;
      base_hs   = hs_cnt;
      base_last = last_cnt;
      base_done = done_cnt;
      do_start(0, 10, 1'b1);
      k = 0;
      while (hs_cnt - base_hs < 2 && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      check("abort_reach_third", hs_cnt - base_hs, 2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_valid_drop", out_valid, 0);
      k = 1;
      while (done_cnt == base_done && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      check("abort_done_seen", done_cnt - base_done, 1);
      check("abort_done_lat_ok", int'(k <= READ_LATENCY + 1), 1);
      check("abort_busy_after", busy, 0);
      check("abort_no_last", last_cnt - base_last, 0);
      check("abort_count", hs_cnt - base_hs, 3);
      sb.delete();
    end
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
